key_encoder83: RTL

- Sequential 8-to-3 priority encoder for the board's eight key/switch lines.
- Converts raw asynchronous active-high key inputs into a registered 3-bit code with press/release strobes.
- Code convention is the exact inverse of the 3-to-8 decoder: key i maps to code i, bit 2 = MSB (a), bit 0 = LSB (c).
- Sits between the pad inputs and the clock/display control logic.

---
 rtl/key_pkg.sv | 22 ++
 rtl/key_debounce.sv | 41 ++++
 rtl/key_encoder83.sv | 95 +++++++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared constants, FSM state encoding and priority helper for the 8-key encoder.
package key_pkg;

    localparam int NKEYS  = 8;
    localparam int CODE_W = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } key_state_t;

    // Index of the highest set bit; 0 when nothing is set.
    function automatic logic [CODE_W-1:0] prio8(input logic [NKEYS-1:0] v);
        logic [CODE_W-1:0] r;
        r = '0;
        for (int i = 0; i < NKEYS; i++) begin
            if (v[i]) r = CODE_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus per-vector debounce; deb only follows a key vector
// that has been stable for DEBOUNCE_CYCLES consecutive synchronized samples.
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NKEYS-1:0] keys,
    output logic [NKEYS-1:0] deb
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NKEYS-1:0] s1, keys_s, cand;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1     <= '0;
            keys_s <= '0;
            cand   <= '0;
            cnt    <= '0;
            deb    <= '0;
        end else begin
            s1     <= keys;
            keys_s <= s1;
            cand   <= keys_s;
            if (keys_s != cand) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                deb <= cand;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_encoder83.sv
// Debounced 8-to-3 priority encoder with registered code/valid/multi and
// one-cycle press/release strobes.
module key_encoder83
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NKEYS-1:0]  keys,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    output logic              press,
    output logic              released,
    output logic              multi
);

    logic [NKEYS-1:0]  deb;
    logic [CODE_W-1:0] deb_code;
    logic              deb_multi;

    key_state_t        state, state_nxt;
    logic [CODE_W-1:0] code_nxt;
    logic              valid_nxt, press_nxt, released_nxt, multi_nxt;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .keys  (keys),
        .deb   (deb)
    );

    assign deb_code  = prio8(deb);
    assign deb_multi = ($countones(deb) >= 2);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            code     <= '0;
            valid    <= 1'b0;
            press    <= 1'b0;
            released <= 1'b0;
            multi    <= 1'b0;
        end else begin
            state    <= state_nxt;
            code     <= code_nxt;
            valid    <= valid_nxt;
            press    <= press_nxt;
            released <= released_nxt;
            multi    <= multi_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        code_nxt     = code;
        valid_nxt    = valid;
        press_nxt    = 1'b0;
        released_nxt = 1'b0;
        multi_nxt    = 1'b0;
        case (state)
            ST_IDLE: begin
                valid_nxt = 1'b0;
                if (deb != '0) begin
                    code_nxt  = deb_code;
                    valid_nxt = 1'b1;
                    press_nxt = 1'b1;
                    multi_nxt = deb_multi;
                    state_nxt = ST_HELD;
                end
            end
            ST_HELD: begin
                if (deb == '0) begin
                    // code keeps the last key so consumers can see what was released
                    valid_nxt    = 1'b0;
                    released_nxt = 1'b1;
                    state_nxt    = ST_IDLE;
                end else begin
                    valid_nxt = 1'b1;
                    multi_nxt = deb_multi;
                    if (deb_code != code) begin
                        code_nxt  = deb_code;
                        press_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
